// File: rtl/score_btn_driver_if.sv
// Command channel into the scoreboard button driver.
// The producer offers an op with cmd_valid; the driver takes it on any
// rising edge where cmd_ready is also high.
interface score_btn_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/score_btn_driver.sv
// Pushbutton stimulus generator for the scoreboard.
// Commands are queued in a small FIFO and replayed one at a time as a
// press/gap waveform on the incr/decr/clr button lines. A saturating BCD
// model tracks the score the scoreboard should be showing.
module score_btn_driver #(
    parameter int PRESS_CYCLES = 20,
    parameter int GAP_CYCLES   = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    score_btn_driver_if.slave    cmd,
    output logic                 btn_incr,
    output logic                 btn_decr,
    output logic                 btn_clr,
    output logic                 busy,
    output logic [3:0]           exp_bcd_hi,
    output logic [3:0]           exp_bcd_low,
    output logic                 cmd_err,
    output logic [CNT_W-1:0]     issued_count
);

    typedef enum logic [1:0] {
        OP_INCR = 2'b00,
        OP_DECR = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP
    } state_t;

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int TMR_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    // The timer only ever holds a load value of (cycles - 1).
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_OCC   = (PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    op_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occupancy;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;
    op_t  in_op;
    op_t  head_op;

    state_t           state;
    logic [TMR_W-1:0] timer;
    op_t              cur_op;
    logic             press_done;

    assign in_op      = op_t'(cmd.cmd_op);
    assign head_op    = fifo_mem[rd_ptr];
    assign fifo_full  = (occupancy == FULL_OCC);
    assign fifo_empty = (occupancy == '0);

    // Ready comes from registered occupancy only, and is held low during reset.
    assign cmd.cmd_ready = ~reset & ~fifo_full;

    // Reserved ops are consumed on the handshake but never queued.
    assign accept = cmd.cmd_valid & cmd.cmd_ready;
    assign push   = accept & (in_op != OP_RSVD);
    // Pop only from IDLE and only from registered occupancy, so a command
    // written on one edge is first visible to the FSM on the next.
    assign pop    = (state == ST_IDLE) & ~fifo_empty;

    // FIFO storage write.
    // NOTE: the storage array has no reset; occupancy and pointers decide
    // which entries are meaningful, so clearing the data buys nothing.
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_op;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Button waveform FSM
    // ------------------------------------------------------------------
    assign press_done = (state == ST_PRESS) && (timer == '0);

    // Sequence IDLE -> PRESS -> GAP and drive the registered button lines.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            cur_op   <= OP_INCR;
            btn_incr <= 1'b0;
            btn_decr <= 1'b0;
            btn_clr  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    btn_incr <= 1'b0;
                    btn_decr <= 1'b0;
                    btn_clr  <= 1'b0;
                    if (!fifo_empty) begin
                        cur_op   <= head_op;
                        timer    <= PRESS_LOAD;
                        state    <= ST_PRESS;
                        btn_incr <= (head_op == OP_INCR);
                        btn_decr <= (head_op == OP_DECR);
                        btn_clr  <= (head_op == OP_CLR);
                    end
                end
                ST_PRESS: begin
                    if (timer == '0) begin
                        btn_incr <= 1'b0;
                        btn_decr <= 1'b0;
                        btn_clr  <= 1'b0;
                        timer    <= GAP_LOAD;
                        state    <= ST_GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    timer    <= '0;
                    btn_incr <= 1'b0;
                    btn_decr <= 1'b0;
                    btn_clr  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE) | ~fifo_empty;

    // ------------------------------------------------------------------
    // Expected score model and bookkeeping
    // ------------------------------------------------------------------

    // Apply the finished command to the saturating 00..99 BCD score.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            exp_bcd_hi  <= 4'd0;
            exp_bcd_low <= 4'd0;
        end else if (press_done) begin
            case (cur_op)
                OP_INCR: begin
                    if (exp_bcd_low != 4'd9) begin
                        exp_bcd_low <= exp_bcd_low + 4'd1;
                    end else if (exp_bcd_hi != 4'd9) begin
                        exp_bcd_low <= 4'd0;
                        exp_bcd_hi  <= exp_bcd_hi + 4'd1;
                    end
                end
                OP_DECR: begin
                    if (exp_bcd_low != 4'd0) begin
                        exp_bcd_low <= exp_bcd_low - 4'd1;
                    end else if (exp_bcd_hi != 4'd0) begin
                        exp_bcd_low <= 4'd9;
                        exp_bcd_hi  <= exp_bcd_hi - 4'd1;
                    end
                end
                OP_CLR: begin
                    exp_bcd_hi  <= 4'd0;
                    exp_bcd_low <= 4'd0;
                end
                default: begin
                    exp_bcd_hi  <= exp_bcd_hi;
                    exp_bcd_low <= exp_bcd_low;
                end
            endcase
        end
    end

    // Count commands whose press phase has completed; wraps naturally.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            issued_count <= '0;
        end else if (press_done) begin
            issued_count <= issued_count + CNT_W'(1);
        end
    end

    // Sticky flag for any accepted reserved op.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cmd_err <= 1'b0;
        end else if (accept && (in_op == OP_RSVD)) begin
            cmd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_score_btn_driver.sv
// Self-checking bench for score_btn_driver.
// A transaction-level model tracks accepted commands in a queue, predicts
// when each press must start from acceptance time and the previous press,
// and keeps the score as a plain integer clamped to 0..99.
module tb_score_btn_driver;

    localparam int PRESS = 20;
    localparam int GAP   = 10;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk_100MHz = 1'b0;
    logic          reset      = 1'b1;
    logic          btn_incr;
    logic          btn_decr;
    logic          btn_clr;
    logic          busy;
    logic [3:0]    exp_bcd_hi;
    logic [3:0]    exp_bcd_low;
    logic          cmd_err;
    logic [CW-1:0] issued_count;

    score_btn_driver_if cmd_if ();

    score_btn_driver #(
        .PRESS_CYCLES (PRESS),
        .GAP_CYCLES   (GAP),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) u_dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .cmd          (cmd_if),
        .btn_incr     (btn_incr),
        .btn_decr     (btn_decr),
        .btn_clr      (btn_clr),
        .busy         (busy),
        .exp_bcd_hi   (exp_bcd_hi),
        .exp_bcd_low  (exp_bcd_low),
        .cmd_err      (cmd_err),
        .issued_count (issued_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Edge counter: value k during the half-cycle after rising edge k.
    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0] op;
        int         acc;   // edge at which the command was accepted
    } cmd_t;

    cmd_t       pend_q[$];
    int         score_m    = 0;
    int         issued_m   = 0;
    bit         err_m      = 1'b0;
    int         last_rise  = -1000;
    logic [1:0] cur_op_m   = 2'b00;
    logic [2:0] prev_btn   = 3'b000;
    int         pulse_cnt[3] = '{0, 0, 0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clk_100MHz) begin : monitor
        logic [2:0] btn;
        logic [2:0] exp_btn;
        cmd_t       c;
        int         exp_rise;
        btn = {btn_clr, btn_decr, btn_incr};
        if (reset) begin
            pend_q.delete();
            score_m   = 0;
            issued_m  = 0;
            err_m     = 1'b0;
            last_rise = -1000;
            prev_btn  = 3'b000;
            check("rst_buttons", {29'd0, btn}, 0);
            check("rst_ready", cmd_if.cmd_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_exp_hi", exp_bcd_hi, 0);
            check("rst_exp_lo", exp_bcd_low, 0);
            check("rst_issued", issued_count, 0);
            check("rst_cmd_err", cmd_err, 0);
        end else begin
            check("onehot", ($countones(btn) <= 1), 1);
            if (prev_btn == 3'b000 && btn != 3'b000) begin
                if (pend_q.size() == 0) begin
                    check("spurious_pulse", {29'd0, btn}, 0);
                end else begin
                    c        = pend_q.pop_front();
                    exp_rise = last_rise + PRESS + GAP + 1;
                    if (c.acc + 1 > exp_rise) exp_rise = c.acc + 1;
                    exp_btn  = 3'b001 << c.op;
                    check("rise_cycle", cyc, exp_rise);
                    check("rise_button", {29'd0, btn}, {29'd0, exp_btn});
                    cur_op_m = c.op;
                end
                last_rise = cyc;
            end else if (prev_btn != 3'b000 && btn == 3'b000) begin
                check("press_width", cyc - last_rise, PRESS);
                pulse_cnt[cur_op_m]++;
                case (cur_op_m)
                    2'b00:   if (score_m < 99) score_m++;
                    2'b01:   if (score_m > 0) score_m--;
                    default: score_m = 0;
                endcase
                issued_m++;
            end else if (prev_btn != 3'b000 && btn != prev_btn) begin
                check("button_switch", {29'd0, btn}, {29'd0, prev_btn});
            end
            prev_btn = btn;
            check("busy", busy, (pend_q.size() != 0) || (cyc < last_rise + PRESS + GAP));
            check("ready", cmd_if.cmd_ready, pend_q.size() < DEPTH);
            check("exp_hi", exp_bcd_hi, score_m / 10);
            check("exp_lo", exp_bcd_low, score_m % 10);
            check("issued", issued_count, CW'(issued_m));
            check("cmd_err", cmd_err, err_m);
        end
    end

    // ------------------------------------------------------------------
    // Drivers (inputs change 1 time unit after the falling edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk_100MHz);
        #1;
    endtask

    // Offer one command until accepted; cmd_valid is left high on return.
    task automatic send(input logic [1:0] op, output bit stalled);
        int tries;
        tries   = 0;
        stalled = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        while (!cmd_if.cmd_ready && tries < 2000) begin
            stalled = 1'b1;
            tick();
            tries++;
        end
        if (!cmd_if.cmd_ready) begin
            check("accept_timeout", cmd_if.cmd_ready, 1);
        end else begin
            if (op == 2'b11) err_m = 1'b1;
            else pend_q.push_back('{op: op, acc: cyc + 1});
            tick();
        end
    endtask

    task automatic idle(input int n);
        cmd_if.cmd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int i;
        i = 0;
        cmd_if.cmd_valid = 1'b0;
        while ((busy || pend_q.size() != 0) && i < 6000) begin
            tick();
            i++;
        end
        check("drain_busy", busy, 0);
        check("drain_queue", pend_q.size(), 0);
        idle(2);
    endtask

    initial begin : global_timeout
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : stim
        bit st;
        bit any_stall;
        int p_incr, p_decr, p_clr;
        int r;
        int w;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        reset            = 1'b1;
        repeat (20) @(negedge clk_100MHz);
        #1 reset = 1'b0;
        idle(3);

        // 1: single incr
        p_incr = pulse_cnt[0];
        send(2'b00, st);
        drain();
        check("t1_exp_hi", exp_bcd_hi, 0);
        check("t1_exp_lo", exp_bcd_low, 1);
        check("t1_issued", issued_count, 1);
        check("t1_pulses", pulse_cnt[0] - p_incr, 1);

        // 2: eight back-to-back incr with valid held high
        any_stall = 1'b0;
        p_incr    = pulse_cnt[0];
        for (int i = 0; i < 8; i++) begin
            send(2'b00, st);
            any_stall |= st;
        end
        drain();
        check("t2_backpressure", any_stall, 1);
        check("t2_pulses", pulse_cnt[0] - p_incr, 8);
        check("t2_exp_hi", exp_bcd_hi, 0);
        check("t2_exp_lo", exp_bcd_low, 9);

        // 3: clear, then decr x3 holds at 00
        p_decr = pulse_cnt[1];
        send(2'b10, st);
        for (int i = 0; i < 3; i++) send(2'b01, st);
        drain();
        check("t3_exp_hi", exp_bcd_hi, 0);
        check("t3_exp_lo", exp_bcd_low, 0);
        check("t3_decr_pulses", pulse_cnt[1] - p_decr, 3);
        check("t3_issued", issued_count, 13);

        // 4: 105 incr saturates at 99
        p_incr = pulse_cnt[0];
        for (int i = 0; i < 105; i++) send(2'b00, st);
        drain();
        check("t4_exp_hi", exp_bcd_hi, 9);
        check("t4_exp_lo", exp_bcd_low, 9);
        check("t4_pulses", pulse_cnt[0] - p_incr, 105);
        check("t4_issued", issued_count, 118);

        // 5: reserved op then clr
        p_clr = pulse_cnt[2];
        send(2'b11, st);
        send(2'b10, st);
        drain();
        check("t5_cmd_err", cmd_err, 1);
        check("t5_clr_pulses", pulse_cnt[2] - p_clr, 1);
        check("t5_exp_lo", exp_bcd_low, 0);
        check("t5_issued", issued_count, 119);

        // 6: reset in the 10th cycle of a press with two commands queued
        send(2'b10, st);
        for (int i = 0; i < 7; i++) send(2'b00, st);
        drain();
        check("t6_pre_hi", exp_bcd_hi, 0);
        check("t6_pre_lo", exp_bcd_low, 7);
        p_incr = pulse_cnt[0];
        for (int i = 0; i < 3; i++) send(2'b00, st);
        cmd_if.cmd_valid = 1'b0;
        w = 0;
        while (!btn_incr && w < 100) begin
            tick();
            w++;
        end
        check("t6_press_seen", btn_incr, 1);
        repeat (9) tick();
        check("t6_queued", pend_q.size(), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(100);
        check("t6_no_pulses", pulse_cnt[0] - p_incr, 0);
        check("t6_busy", busy, 0);
        check("t6_exp_lo", exp_bcd_low, 0);
        check("t6_issued", issued_count, 0);

        // Random mix of commands and idle gaps
        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 99);
            if (i < 12)      send(2'b00, st);
            else if (r < 45) send(2'b00, st);
            else if (r < 85) send(2'b01, st);
            else if (r < 95) send(2'b10, st);
            else             send(2'b11, st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 40));
        end
        drain();
        check("rand_issued", issued_count, CW'(issued_m));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
